// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max-pooling stage. Consumes nok parallel raster-order
// pixel streams and emits floor(im/2) x floor(im/2) pooled maps per lane,
// keeping only a half-row line buffer of horizontal maxima per lane.
module max_pool_2x2 #(
  parameter int N   = 7,
  parameter int nok = 6,
  parameter int im  = 220
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [0:nok-1][2*N+1:0]   data,
  input  logic                      in_valid,
  output logic [0:nok-1][2*N+1:0]   out,
  output logic                      out_valid,
  output logic                      finish
);

  localparam int W    = 2 * N + 2;
  localparam int HALF = im / 2;
  localparam int BD   = (HALF > 1) ? HALF : 1;
  localparam int CW   = (im > 1) ? $clog2(im) : 1;
  localparam int IW   = (BD > 1) ? $clog2(BD) : 1;
  localparam logic [CW-1:0] LAST = CW'(im - 1);

  logic [CW-1:0]             col;
  logic [CW-1:0]             row;
  logic [0:nok-1][W-1:0]     h;
  logic [0:nok-1][W-1:0]     hm;
  logic [0:nok-1][W-1:0]     pooled;
  logic [W-1:0]              line_buf [0:nok-1][0:BD-1];
  logic                      accept;
  logic [IW-1:0]             idx;

  assign accept = in_valid & ~finish;
  assign idx    = IW'(col >> 1);

  // Horizontal max of the latched even pixel and the current odd pixel, then
  // the vertical max against the stored even-row result, per lane (signed).
  always_comb begin
    hm     = '0;
    pooled = '0;
    for (int unsigned k = 0; k < nok; k++) begin
      hm[k]     = ($signed(data[k]) > $signed(h[k])) ? data[k] : h[k];
      pooled[k] = ($signed(line_buf[k][idx]) > $signed(hm[k])) ? line_buf[k][idx] : hm[k];
    end
  end

  // Even rows park their horizontal maxima here; entries are always written
  // before the following odd row reads them, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!reset && accept && col[0] && !row[0]) begin
      for (int unsigned k = 0; k < nok; k++) begin
        line_buf[k][idx] <= hm[k];
      end
    end
  end

  // Raster counters, even-column latch, registered pooled output and finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      h         <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      finish    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (!col[0]) begin
          h <= data;
        end
        if (col[0] && row[0]) begin
          out       <= pooled;
          out_valid <= 1'b1;
        end
        if (col == LAST) begin
          col <= '0;
          if (row == LAST) begin
            row    <= '0;
            finish <= 1'b1;
          end else begin
            row <= row + CW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2: table-driven ramp/post-finish vectors,
// directed signed and odd-size sequences, and randomized frames checked
// against a full-frame reference model with a timed scoreboard.
module tb_max_pool_2x2;

  localparam int IM4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // main DUT: im=4, 2 lanes
  logic              rst4 = 1'b1, iv4 = 1'b0;
  logic [0:1][15:0]  d4 = '0, o4;
  logic              ov4, fin4;
  max_pool_2x2 #(.N(7), .nok(2), .im(4)) u4 (
    .clk(clk), .reset(rst4), .data(d4), .in_valid(iv4),
    .out(o4), .out_valid(ov4), .finish(fin4));

  // signed check: im=2, 1 lane
  logic              rst2 = 1'b1, iv2 = 1'b0;
  logic [0:0][15:0]  d2 = '0, o2;
  logic              ov2, fin2;
  max_pool_2x2 #(.N(7), .nok(1), .im(2)) u2 (
    .clk(clk), .reset(rst2), .data(d2), .in_valid(iv2),
    .out(o2), .out_valid(ov2), .finish(fin2));

  // odd size: im=5, 2 lanes
  logic              rst5 = 1'b1, iv5 = 1'b0;
  logic [0:1][15:0]  d5 = '0, o5;
  logic              ov5, fin5;
  max_pool_2x2 #(.N(7), .nok(2), .im(5)) u5 (
    .clk(clk), .reset(rst5), .data(d5), .in_valid(iv5),
    .out(o5), .out_valid(ov5), .finish(fin5));

  // ---------------- reference model for u4 ----------------
  typedef struct { logic [15:0] v0; logic [15:0] v1; int due; } exp_t;
  exp_t sbq[$];
  int   frame [0:IM4-1][0:IM4-1][0:1];
  int   mr = 0, mc = 0;
  bit   mfin = 0;
  int   rst_at = -1, fin_at = -1;
  bit   exp_fin = 0;
  logic [15:0] last0 = '0, last1 = '0;
  bit   mon_on = 0;
  int   outs4 = 0;

  function automatic int max4(input int r, input int c, input int k);
    int m = frame[r-1][c-1][k];
    if (frame[r-1][c][k] > m) m = frame[r-1][c][k];
    if (frame[r][c-1][k] > m) m = frame[r][c-1][k];
    if (frame[r][c][k]   > m) m = frame[r][c][k];
    return m;
  endfunction

  task automatic drive4(input logic v, input logic r, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    rst4 = r; iv4 = v; d4[0] = a; d4[1] = b;
    if (r) begin
      rst_at = cyc + 1; mr = 0; mc = 0; mfin = 0;
    end else if (v && !mfin) begin
      frame[mr][mc][0] = $signed(a);
      frame[mr][mc][1] = $signed(b);
      if ((mr % 2 == 1) && (mc % 2 == 1) && (mr < 2 * (IM4 / 2)) && (mc < 2 * (IM4 / 2))) begin
        e.v0  = 16'(max4(mr, mc, 0));
        e.v1  = 16'(max4(mr, mc, 1));
        e.due = cyc + 1;
        sbq.push_back(e);
      end
      if (mc == IM4 - 1) begin
        mc = 0;
        if (mr == IM4 - 1) begin mfin = 1; fin_at = cyc + 1; end
        else mr++;
      end else mc++;
    end
  endtask

  task automatic step4(input logic v, input logic r, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    drive4(v, r, a, b);
  endtask

  // Scoreboard: timing, values, hold behaviour and finish of u4.
  always @(negedge clk) begin
    if (mon_on) begin
      if (cyc == rst_at) begin exp_fin = 0; last0 = '0; last1 = '0; end
      if (cyc == fin_at) exp_fin = 1;
      chk("sb_finish", 32'(fin4), 32'(exp_fin));
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        chk("sb_missed_output", 32'(sbq[0].due), 32'(cyc));
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        chk("sb_valid", 32'(ov4), 32'd1);
        chk("sb_lane0", 32'(o4[0]), 32'(sbq[0].v0));
        chk("sb_lane1", 32'(o4[1]), 32'(sbq[0].v1));
        last0 = sbq[0].v0; last1 = sbq[0].v1;
        void'(sbq.pop_front());
      end else begin
        chk("sb_no_valid", 32'(ov4), 32'd0);
        chk("sb_hold0", 32'(o4[0]), 32'(last0));
        chk("sb_hold1", 32'(o4[1]), 32'(last1));
      end
      if (ov4) outs4++;
    end
  end

  // ---------------- table for the im=4 ramp + post-finish ----------------
  typedef struct {
    logic v; logic [15:0] d0; logic [15:0] d1;
    logic eov; logic [15:0] e0; logic [15:0] e1; logic efin;
  } vec_t;
  vec_t tbl [0:21];

  initial begin : main
    int base;
    int got;
    int resets;
    logic [15:0] sv2 [0:3];
    logic [15:0] g0 [$];
    logic [15:0] g1 [$];
    int gp [$];
    logic [15:0] x0 [0:3];
    logic [15:0] x1 [0:3];
    int xp [0:3];

    // Entry i: inputs applied this cycle, outputs expected in this cycle
    // (i.e. the response to entry i-1).
    for (int i = 0; i < 22; i++) begin
      tbl[i].v = 1'b0; tbl[i].d0 = '0; tbl[i].d1 = '0;
      tbl[i].eov = (i == 6) || (i == 8) || (i == 14) || (i == 16);
      tbl[i].efin = (i >= 16);
      if (i < 6)       begin tbl[i].e0 = 16'd0;  tbl[i].e1 = 16'd0;  end
      else if (i < 8)  begin tbl[i].e0 = 16'd5;  tbl[i].e1 = 16'd10; end
      else if (i < 14) begin tbl[i].e0 = 16'd7;  tbl[i].e1 = 16'd14; end
      else if (i < 16) begin tbl[i].e0 = 16'd13; tbl[i].e1 = 16'd26; end
      else             begin tbl[i].e0 = 16'd15; tbl[i].e1 = 16'd30; end
    end
    for (int p = 0; p < 16; p++) begin
      tbl[p].v = 1'b1; tbl[p].d0 = 16'(p); tbl[p].d1 = 16'(2 * p);
    end
    for (int i = 18; i < 21; i++) begin
      tbl[i].v = 1'b1; tbl[i].d0 = 16'h7fff; tbl[i].d1 = 16'h7ffe;
    end

    // ---- reset all ----
    step4(1'b0, 1'b1, '0, '0);
    rst2 = 1'b1; rst5 = 1'b1;
    step4(1'b0, 1'b0, '0, '0);
    rst2 = 1'b0; rst5 = 1'b0;
    mon_on = 1;

    // ---- table: ramp back-to-back, then 3 beats after finish ----
    for (int i = 0; i < 22; i++) begin
      step4(tbl[i].v, 1'b0, tbl[i].d0, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(ov4), 32'(tbl[i].eov));
      chk($sformatf("tbl%0d_lane0", i), 32'(o4[0]), 32'(tbl[i].e0));
      chk($sformatf("tbl%0d_lane1", i), 32'(o4[1]), 32'(tbl[i].e1));
      chk($sformatf("tbl%0d_finish", i), 32'(fin4), 32'(tbl[i].efin));
    end

    // ---- gapped ramp ----
    step4(1'b0, 1'b1, '0, '0);
    base = outs4;
    for (int p = 0; p < 16; p++) begin
      step4(1'b1, 1'b0, 16'(p), 16'(2 * p));
      step4(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      if (p == 5) for (int g = 0; g < 10; g++) step4(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    end
    step4(1'b0, 1'b0, '0, '0);
    step4(1'b0, 1'b0, '0, '0);
    chk("gap_outputs", 32'(outs4 - base), 32'd4);
    chk("gap_finish", 32'(fin4), 32'd1);

    // ---- reset mid-frame (reset coincides with a valid beat) ----
    step4(1'b0, 1'b1, '0, '0);
    for (int p = 0; p < 6; p++) step4(1'b1, 1'b0, 16'h4000 + 16'(p), 16'h4100 + 16'(p));
    step4(1'b1, 1'b1, 16'h7fff, 16'h7fff);
    base = outs4;
    for (int p = 0; p < 16; p++) begin
      step4(1'b1, 1'b0, 16'(p), 16'(2 * p));
      @(negedge clk);
      if (p == 15) chk("rst_no_early_finish", 32'(fin4), 32'd0);
    end
    step4(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rst_outputs", 32'(outs4 - base), 32'd4);
    chk("rst_lane0_last", 32'(o4[0]), 32'd15);
    chk("rst_finish", 32'(fin4), 32'd1);

    // ---- randomized frames ----
    for (int f = 0; f < 6; f++) begin
      step4(1'b0, 1'b1, '0, '0);
      resets = 0;
      for (int n = 0; n < 400 && !mfin; n++) begin
        if (resets == 0 && $urandom_range(0, 39) == 0) begin
          step4(1'b1, 1'b1, 16'($urandom), 16'($urandom));
          resets++;
        end else begin
          step4(1'($urandom_range(0, 9) < 7), 1'b0, 16'($urandom), 16'($urandom));
        end
      end
      if (!mfin) chk("rand_frame_budget", 32'd0, 32'd1);
      for (int p = 0; p < 3; p++) step4(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      step4(1'b0, 1'b0, '0, '0);
      step4(1'b0, 1'b0, '0, '0);
      chk("rand_finish", 32'(fin4), 32'd1);
    end
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    // ---- signed, im=2, one lane ----
    sv2[0] = 16'hfffd; sv2[1] = 16'hfff8; sv2[2] = 16'hffff; sv2[3] = 16'hffec;
    for (int p = 0; p < 5; p++) begin
      @(posedge clk); #1;
      iv2 = (p < 4); d2[0] = (p < 4) ? sv2[p] : 16'h7fff;
      @(negedge clk);
      if (p == 3) begin
        chk("s2_early_valid", 32'(ov2), 32'd0);
        chk("s2_early_finish", 32'(fin2), 32'd0);
      end
      if (p == 4) begin
        chk("s2_valid", 32'(ov2), 32'd1);
        chk("s2_value", 32'(o2[0]), 32'h0000ffff);
        chk("s2_finish", 32'(fin2), 32'd1);
      end
    end
    iv2 = 1'b0;

    // ---- odd size, im=5 ----
    x0[0] = 16'd6;  x0[1] = 16'd8;  x0[2] = 16'd16; x0[3] = 16'd18;
    x1[0] = 16'd12; x1[1] = 16'd16; x1[2] = 16'd32; x1[3] = 16'd36;
    xp[0] = 7; xp[1] = 9; xp[2] = 17; xp[3] = 19;
    for (int p = 0; p < 28; p++) begin
      @(posedge clk); #1;
      iv5 = (p < 25); d5[0] = 16'(p); d5[1] = 16'(2 * p);
      @(negedge clk);
      if (ov5) begin g0.push_back(o5[0]); g1.push_back(o5[1]); gp.push_back(p); end
      if (p == 24) chk("o5_finish_early", 32'(fin5), 32'd0);
      if (p == 25) chk("o5_finish", 32'(fin5), 32'd1);
    end
    iv5 = 1'b0;
    got = g0.size();
    chk("o5_count", 32'(got), 32'd4);
    for (int i = 0; i < 4 && i < got; i++) begin
      chk($sformatf("o5_lane0_%0d", i), 32'(g0[i]), 32'(x0[i]));
      chk($sformatf("o5_lane1_%0d", i), 32'(g1[i]), 32'(x1[i]));
      chk($sformatf("o5_cycle_%0d", i), 32'(gp[i]), 32'(xp[i]));
    end

    mon_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
